// File: rtl/vc_input_buffer_pkg.sv
// -----------------------------------------------------------------------------
// vc_input_buffer_pkg
// Shared router definitions used by the VC input buffer and its slices.
//   FLIT_DATA_WIDTH : default flit payload width
//   ROUTER_NUM_VC   : VC count of the standard router build
//   vc_id_t         : VC identifier sized for ROUTER_NUM_VC
//   wrap_inc()      : modulo-depth pointer increment (any depth, not only 2^n)
// -----------------------------------------------------------------------------
package vc_input_buffer_pkg;

  localparam int FLIT_DATA_WIDTH = 8;
  localparam int ROUTER_NUM_VC   = 4;

  typedef logic [$clog2(ROUTER_NUM_VC)-1:0] vc_id_t;

  // Next pointer value, wrapping from depth-1 back to 0.
  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/vc_input_buffer_slice.sv
// -----------------------------------------------------------------------------
// vc_buf_slice
// Storage, read/write pointers and occupancy counter for a single virtual
// channel. Write/read enables arrive already qualified (accepted) from the
// parent, so this block never has to reason about full/empty rejection.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset (pointers/count only)
//   wr_en   in   accepted write this cycle
//   wr_data in   flit to store
//   rd_en   in   accepted read this cycle
//   rd_data out  head flit (undefined when empty)
//   count   out  occupancy 0..DEPTH
//   empty   out  count == 0
//   full    out  count == DEPTH
// -----------------------------------------------------------------------------
module vc_buf_slice
  import vc_input_buffer_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  int DATA_WIDTH = FLIT_DATA_WIDTH,
  localparam int PW         = $clog2(DEPTH),
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = PW'(wrap_inc(int'(wr_ptr_q), DEPTH));
    if (rd_en) rd_ptr_d = PW'(wrap_inc(int'(rd_ptr_q), DEPTH));
    // Simultaneous write and read leaves occupancy unchanged.
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Flit storage is deliberately not reset; the cleared count hides stale data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;

endmodule

// File: rtl/vc_input_buffer.sv
// -----------------------------------------------------------------------------
// vc_input_buffer
// Router input port buffer with NUM_VC independent FIFO virtual channels.
// Decodes push/pop to one VC slice, muxes the head flit of pop_vc and returns
// a registered one-cycle credit for every accepted pop.
// Optional feature macro: VC_BUF_ERR_EN adds a sticky 'err' output that sets
// on any rejected push (VC full) or pop (VC empty) and clears only on reset.
// Ports:
//   clk, reset           clock / async active-low reset
//   push, push_vc/data   write request
//   pop, pop_vc          read request
//   pop_data             head flit of pop_vc (combinational)
//   vc_empty, vc_full    per-VC flags
//   vc_count             flattened per-VC occupancy, VC0 in LSBs
//   credit_valid/vc      registered credit-return pulse
//   err                  (VC_BUF_ERR_EN only) sticky rejection flag
// -----------------------------------------------------------------------------
module vc_input_buffer
  import vc_input_buffer_pkg::*;
#(
  parameter  int NUM_VC     = 4,
  parameter  int VC_DEPTH   = 4,
  parameter  int DATA_WIDTH = FLIT_DATA_WIDTH,
  localparam int VC_W       = $clog2(NUM_VC),
  localparam int CW         = $clog2(VC_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [VC_W-1:0]        push_vc,
  input  logic [DATA_WIDTH-1:0]  push_data,
  input  logic                   pop,
  input  logic [VC_W-1:0]        pop_vc,
  output logic [DATA_WIDTH-1:0]  pop_data,
  output logic [NUM_VC-1:0]      vc_empty,
  output logic [NUM_VC-1:0]      vc_full,
  output logic [NUM_VC*CW-1:0]   vc_count,
  output logic                   credit_valid,
`ifdef VC_BUF_ERR_EN
  output logic                   err,
`endif
  output logic [VC_W-1:0]        credit_vc
);

  logic [NUM_VC-1:0]     wr_acc, rd_acc;
  logic [DATA_WIDTH-1:0] head [NUM_VC];
  logic                  pop_ok;
  logic                  credit_valid_q;
  logic [VC_W-1:0]       credit_vc_q, credit_vc_d;

  // One-hot accept decode; a VC index beyond NUM_VC never matches.
  always_comb begin
    wr_acc = '0;
    rd_acc = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      wr_acc[v] = push && (int'(push_vc) == v) && !vc_full[v];
      rd_acc[v] = pop  && (int'(pop_vc)  == v) && !vc_empty[v];
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_buf_slice #(
      .DEPTH      (VC_DEPTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slice (
      .clk     (clk),
      .rst_n   (reset),
      .wr_en   (wr_acc[v]),
      .wr_data (push_data),
      .rd_en   (rd_acc[v]),
      .rd_data (head[v]),
      .count   (vc_count[v*CW +: CW]),
      .empty   (vc_empty[v]),
      .full    (vc_full[v])
    );
  end

  always_comb begin
    pop_data = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      if (int'(pop_vc) == v) pop_data = head[v];
    end
  end

  assign pop_ok      = |rd_acc;
  // credit_vc holds its last value between pulses.
  assign credit_vc_d = pop_ok ? pop_vc : credit_vc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credit_valid_q <= 1'b0;
      credit_vc_q    <= '0;
    end else begin
      credit_valid_q <= pop_ok;
      credit_vc_q    <= credit_vc_d;
    end
  end

  assign credit_valid = credit_valid_q;
  assign credit_vc    = credit_vc_q;

`ifdef VC_BUF_ERR_EN
  logic err_q, err_d;

  assign err_d = err_q || (push && !(|wr_acc)) || (pop && !pop_ok);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_vc_input_buffer
// Self-checking bench: directed scenarios followed by random traffic, all
// compared against a queue-per-VC reference model.
// -----------------------------------------------------------------------------
module tb_vc_input_buffer;
  import vc_input_buffer_pkg::*;

  localparam int NUM_VC = 4;
  localparam int DEPTH  = 4;
  localparam int DW     = FLIT_DATA_WIDTH;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic                 clk;
  logic                 reset;
  logic                 push;
  vc_id_t               push_vc;
  logic [DW-1:0]        push_data;
  logic                 pop;
  vc_id_t               pop_vc;
  logic [DW-1:0]        pop_data;
  logic [NUM_VC-1:0]    vc_empty;
  logic [NUM_VC-1:0]    vc_full;
  logic [NUM_VC*CW-1:0] vc_count;
  logic                 credit_valid;
  vc_id_t               credit_vc;
`ifdef VC_BUF_ERR_EN
  logic                 err;
`endif

  vc_input_buffer #(
    .NUM_VC     (NUM_VC),
    .VC_DEPTH   (DEPTH),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_vc      (push_vc),
    .push_data    (push_data),
    .pop          (pop),
    .pop_vc       (pop_vc),
    .pop_data     (pop_data),
    .vc_empty     (vc_empty),
    .vc_full      (vc_full),
    .vc_count     (vc_count),
    .credit_valid (credit_valid),
`ifdef VC_BUF_ERR_EN
    .err          (err),
`endif
    .credit_vc    (credit_vc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: one queue per VC plus expected credit/err state.
  logic [DW-1:0] mq [NUM_VC][$];
  bit            exp_cv;
  int            exp_cvc;
  bit            exp_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int v = 0; v < NUM_VC; v++) mq[v].delete();
    exp_cv  = 0;
    exp_cvc = 0;
    exp_err = 0;
  endtask

  task automatic check_state(input string tag);
    logic [NUM_VC-1:0]    e_empty, e_full;
    logic [NUM_VC*CW-1:0] e_cnt;
    for (int v = 0; v < NUM_VC; v++) begin
      e_empty[v]         = (mq[v].size() == 0);
      e_full[v]          = (mq[v].size() == DEPTH);
      e_cnt[v*CW +: CW]  = CW'(mq[v].size());
    end
    chk({tag, ".empty"},    64'(vc_empty),     64'(e_empty));
    chk({tag, ".full"},     64'(vc_full),      64'(e_full));
    chk({tag, ".count"},    64'(vc_count),     64'(e_cnt));
    chk({tag, ".credit_v"}, 64'(credit_valid), 64'(exp_cv));
    chk({tag, ".credit_vc"},64'(credit_vc),    64'(exp_cvc));
`ifdef VC_BUF_ERR_EN
    chk({tag, ".err"},      64'(err),          64'(exp_err));
`endif
  endtask

  // One clock of stimulus. Entered and left at posedge+1.
  task automatic cycle(input bit ph, input int pv, input logic [DW-1:0] pd,
                       input bit pp, input int ov, input string tag,
                       input bit has_want = 0, input logic [DW-1:0] want = '0);
    bit acc_w, acc_r;
    push      = ph;
    push_vc   = vc_id_t'(pv);
    push_data = pd;
    pop       = pp;
    pop_vc    = vc_id_t'(ov);
    @(negedge clk);
    if (mq[ov].size() > 0) chk({tag, ".pop_data"}, 64'(pop_data), 64'(mq[ov][0]));
    if (has_want)          chk({tag, ".want"},     64'(pop_data), 64'(want));
    @(posedge clk);
    acc_w = ph && (mq[pv].size() < DEPTH);
    acc_r = pp && (mq[ov].size() > 0);
    if (acc_r) void'(mq[ov].pop_front());
    if (acc_w) mq[pv].push_back(pd);
    exp_cv = acc_r;
    if (acc_r) exp_cvc = ov;
    if ((ph && !acc_w) || (pp && !acc_r)) exp_err = 1;
    #1;
    check_state(tag);
  endtask

  task automatic idle(input string tag);
    cycle(0, 0, '0, 0, 0, tag);
  endtask

  initial begin
    push = 0; push_vc = '0; push_data = '0; pop = 0; pop_vc = '0;
    reset = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check_state("in_reset");
    reset = 1'b1;
    @(posedge clk); #1;
    idle("reset_idle");

    // VC2 fill to full, overflow attempt, then drain in order.
    for (int i = 0; i < 4; i++) cycle(1, 2, DW'(8'hA0 + i), 0, 0, "fill_vc2");
    chk("vc2_full", 64'(vc_full[2]), 64'd1);
    cycle(1, 2, DW'(8'hA4), 0, 0, "overflow_vc2");
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, 2, "drain_vc2", 1, DW'(8'hA0 + i));
    idle("after_drain");

    // Interleaved VC0 / VC3 traffic.
    cycle(1, 0, DW'(8'h10), 0, 0, "il_push0");
    cycle(1, 3, DW'(8'h30), 0, 0, "il_push3");
    cycle(1, 0, DW'(8'h11), 0, 0, "il_push0b");
    cycle(0, 0, '0, 1, 3, "il_pop3", 1, DW'(8'h30));
    cycle(0, 0, '0, 1, 0, "il_pop0", 1, DW'(8'h10));
    cycle(0, 0, '0, 1, 0, "il_pop0b", 1, DW'(8'h11));

    // VC1 steady state: simultaneous push/pop with wraparound.
    cycle(1, 1, DW'(8'h50), 0, 0, "ss_pre0");
    cycle(1, 1, DW'(8'h51), 0, 0, "ss_pre1");
    for (int i = 0; i < 6; i++) cycle(1, 1, DW'(8'h52 + i), 1, 1, "ss_both", 1, DW'(8'h50 + i));
    chk("ss_count", 64'(vc_count[1*CW +: CW]), 64'd2);
    cycle(0, 0, '0, 1, 1, "ss_pop_a", 1, DW'(8'h56));
    cycle(0, 0, '0, 1, 1, "ss_pop_b", 1, DW'(8'h57));

    // Credits: pop of VC2, then pop of empty VC0, then push+pop empty VC3.
    cycle(1, 2, DW'(8'h77), 0, 0, "cr_push");
    cycle(0, 0, '0, 1, 2, "cr_pop2");
    chk("cr_vc2", 64'(credit_vc), 64'd2);
    idle("cr_gone");
    cycle(0, 0, '0, 1, 0, "cr_empty0");
    cycle(1, 3, DW'(8'h33), 1, 3, "wr_rd_empty");
    cycle(0, 0, '0, 1, 3, "wr_rd_empty_pop", 1, DW'(8'h33));

    // Full VC with simultaneous pop: the write is rejected.
    for (int i = 0; i < 4; i++) cycle(1, 1, DW'(8'hC0 + i), 0, 0, "fullrd_fill");
    cycle(1, 1, DW'(8'hCF), 1, 1, "fullrd_both", 1, DW'(8'hC0));
    for (int i = 1; i < 4; i++) cycle(0, 0, '0, 1, 1, "fullrd_drain", 1, DW'(8'hC0 + i));

    // Asynchronous reset in the middle of a VC0 burst.
    for (int i = 0; i < 3; i++) cycle(1, 0, DW'(8'hE0 + i), 0, 0, "mid_fill");
    push = 1; push_vc = 0; push_data = DW'(8'hEE);
    #2 reset = 1'b0;
    #1;
    model_clear();
    check_state("async_rst");
    push = 0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check_state("rst_release");
    cycle(1, 0, DW'(8'h99), 0, 0, "post_rst_push");
    cycle(0, 0, '0, 1, 0, "post_rst_pop", 1, DW'(8'h99));

    // Random traffic, biased to hit full and empty often.
    for (int i = 0; i < 600; i++) begin
      bit ph, pp;
      int pv, ov;
      ph = ($urandom_range(0, 99) < 55);
      pp = ($urandom_range(0, 99) < 45);
      pv = $urandom_range(0, NUM_VC - 1);
      ov = $urandom_range(0, NUM_VC - 1);
      cycle(ph, pv, DW'($urandom), pp, ov, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vc_input_buffer.md
VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

Interface
REQ-001 SHALL have parameter NUM_VC, default 4, number of virtual channels (>=2).
REQ-002 SHALL have parameter VC_DEPTH, default 4, flits per VC (>=2, any integer, not only power of two).
REQ-003 SHALL have parameter DATA_WIDTH, default FLIT_DATA_WIDTH from the shared package, flit width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset; state clears while reset is 0.
REQ-006 SHALL have port push  input  1  write request.
REQ-007 SHALL have port push_vc  input  $clog2(NUM_VC)  target VC of write.
REQ-008 SHALL have port push_data  input  DATA_WIDTH  flit to write.
REQ-009 SHALL have port pop  input  1  read request.
REQ-010 SHALL have port pop_vc  input  $clog2(NUM_VC)  source VC of read.
REQ-011 SHALL have port pop_data  output  DATA_WIDTH  head flit of pop_vc, combinational.
REQ-012 SHALL have port vc_empty  output  NUM_VC  per-VC empty flag.
REQ-013 SHALL have port vc_full  output  NUM_VC  per-VC full flag.
REQ-014 SHALL have port vc_count  output  NUM_VC*($clog2(VC_DEPTH)+1)  flattened per-VC occupancy, VC0 in LSBs.
REQ-015 SHALL have port credit_valid  output  1  credit-return pulse to upstream.
REQ-016 SHALL have port credit_vc  output  $clog2(NUM_VC)  VC being credited.

Function
REQ-017 SHALL accept a write only when push=1 and vc_full[push_vc]=0; a rejected write changes no state.
REQ-018 SHALL accept a read only when pop=1 and vc_empty[pop_vc]=0; a rejected read changes no state.
REQ-019 SHALL make a written flit visible on pop_data from the cycle after the accepting edge (no same-cycle bypass).
REQ-020 SHALL keep each VC in FIFO order, independent of all other VCs.
REQ-021 SHALL advance each VC read and write pointer modulo VC_DEPTH, wrapping from VC_DEPTH-1 to 0.
REQ-022 SHALL track occupancy with a per-VC counter: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-023 SHALL derive vc_empty = (count==0) and vc_full = (count==VC_DEPTH), with no last-operation flag.
REQ-024 SHALL, on simultaneous accepted write and read to the same VC, write and read in the same edge with the count unchanged.
REQ-025 SHALL reject a write to a full VC even if the same VC is read in that cycle.
REQ-026 SHALL, on a write and a read to an empty VC in the same cycle, accept the write and reject the read.
REQ-027 SHALL drive credit_valid=1 and credit_vc=pop_vc, registered, for exactly one cycle after each accepted read.
REQ-028 SHALL leave pop_data undefined (don't-care) when vc_empty[pop_vc]=1.

Reset
REQ-029 SHALL, while reset=0, clear all pointers and counts to 0, vc_empty to all-ones, vc_full to 0, credit_valid and credit_vc to 0, and err (when present) to 0.
REQ-030 SHALL discard all buffered flits on reset mid-operation; storage contents are not reset.

Configuration
REQ-031 SHALL, with VC_BUF_ERR_EN defined, add an output port err (1 bit) that is set sticky on any rejected push or pop request and cleared only by reset.
REQ-032 SHALL, without VC_BUF_ERR_EN, have no err port, with rejected requests silently ignored.

Structure
REQ-033 SHALL take FLIT_DATA_WIDTH and a vc_id_t typedef from the shared router package.
REQ-034 SHALL instantiate NUM_VC copies of one sub-module, vc_buf_slice, each holding storage, pointers and counter for one VC.
REQ-035 SHALL keep write and read VC decode, pop_data mux and credit register in vc_input_buffer.

Verification
REQ-036 Reset, then idle -> vc_empty=4'b1111, vc_full=0, all counts 0, credit_valid=0.
REQ-037 Push 4 flits 0xA0..0xA3 to VC2, then a 5th push -> vc_full[2]=1, count=4, 5th dropped (err=1 when VC_BUF_ERR_EN is defined), pops return 0xA0..0xA3.
REQ-038 Interleave pushes to VC0 (0x10,0x11) and VC3 (0x30) -> pop VC3 gives 0x30, pop VC0 gives 0x10 then 0x11, other VCs unaffected.
REQ-039 VC1 holding 2 flits, push and pop VC1 in the same cycle for 6 cycles -> count stays 2, pointers wrap, FIFO order preserved.
REQ-040 Each accepted pop of VC2 -> credit_valid=1 with credit_vc=2 on the next cycle only; a pop of empty VC0 produces no credit.
REQ-041 Assert reset with VC0 at 3 flits mid-burst -> all flags and counts return to reset values asynchronously, and a new push/pop works after release.
